// File: rtl/fpu_arbiter_if.sv
// Requester, response and FPU-side signal bundle for fpu_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface fpu_arbiter_if #(
  parameter int CTL_W  = 5,
  parameter int DATA_W = 32
);
  logic              r0_valid;
  logic              r0_ready;
  logic [CTL_W-1:0]  r0_ctl;
  logic [DATA_W-1:0] r0_x1;
  logic [DATA_W-1:0] r0_x2;
  logic              r0_rsp_valid;
  logic              r0_rsp_ready;

  logic              r1_valid;
  logic              r1_ready;
  logic [CTL_W-1:0]  r1_ctl;
  logic [DATA_W-1:0] r1_x1;
  logic [DATA_W-1:0] r1_x2;
  logic              r1_rsp_valid;
  logic              r1_rsp_ready;

  logic [DATA_W-1:0] rsp_y;
  logic              rsp_err;

  logic              fpu_en;
  logic [CTL_W-1:0]  fpu_ctl;
  logic [DATA_W-1:0] fpu_x1;
  logic [DATA_W-1:0] fpu_x2;
  logic              fpu_ready;
  logic [DATA_W-1:0] fpu_y;

  logic              busy;

  modport slave (
    input  r0_valid, r0_ctl, r0_x1, r0_x2, r0_rsp_ready,
    input  r1_valid, r1_ctl, r1_x1, r1_x2, r1_rsp_ready,
    input  fpu_ready, fpu_y,
    output r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
    output rsp_y, rsp_err, fpu_en, fpu_ctl, fpu_x1, fpu_x2, busy
  );

  modport master (
    output r0_valid, r0_ctl, r0_x1, r0_x2, r0_rsp_ready,
    output r1_valid, r1_ctl, r1_x1, r1_x2, r1_rsp_ready,
    output fpu_ready, fpu_y,
    input  r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid,
    input  rsp_y, rsp_err, fpu_en, fpu_ctl, fpu_x1, fpu_x2, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one FPU between two requesters, with a valid/ready response path.
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int CTL_W   = 5,
  parameter int DATA_W  = 32,
  parameter int MAX_CTL = 20,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [CTL_W-1:0] MAX_CTL_L = CTL_W'(MAX_CTL);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              err_q, err_d;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
  logic [7:0] wcnt_q, wcnt_d;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  logic              grant;
  logic              accept;
  logic              own_rsp_ready;
  logic [CTL_W-1:0]  sel_ctl;
  logic [DATA_W-1:0] sel_x1;
  logic [DATA_W-1:0] sel_x2;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (bus.r0_valid && bus.r1_valid) grant = ~last_grant_q;
    else if (bus.r1_valid)            grant = 1'b1;
  end

  assign bus.r0_ready = (state_q == S_IDLE) && !grant && bus.r0_valid;
  assign bus.r1_ready = (state_q == S_IDLE) &&  grant && bus.r1_valid;
  assign accept       = bus.r0_ready || bus.r1_ready;

  assign sel_ctl       = grant ? bus.r1_ctl : bus.r0_ctl;
  assign sel_x1        = grant ? bus.r1_x1  : bus.r0_x1;
  assign sel_x2        = grant ? bus.r1_x2  : bus.r0_x2;
  assign own_rsp_ready = owner_q ? bus.r1_rsp_ready : bus.r0_rsp_ready;

  // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ctl_d        = ctl_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y_d          = y_q;
    err_d        = err_q;
`ifdef FPU_ARB_TIMEOUT_EN
    wcnt_d       = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant;
          ctl_d   = sel_ctl;
          x1_d    = sel_x1;
          x2_d    = sel_x2;
          if (sel_ctl <= MAX_CTL_L) begin
            state_d = S_ISSUE;
          end else begin
            // Unknown opcode: answer with an error without ever pulsing the FPU.
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (bus.fpu_ready) begin
          y_d     = bus.fpu_y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (wcnt_q == TIMEOUT_L - 8'd1) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (own_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      // NOTE: the operand and result registers drive outputs directly, so they are reset rather than left undefined.
      ctl_q        <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ctl_q        <= ctl_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y_q          <= y_d;
      err_q        <= err_d;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`endif

  // Operands stay parked through WAIT: the FPU picks its result by ctl at completion.
  assign bus.fpu_en       = (state_q == S_ISSUE);
  assign bus.fpu_ctl      = ctl_q;
  assign bus.fpu_x1       = x1_q;
  assign bus.fpu_x2       = x2_q;
  assign bus.rsp_y        = y_q;
  assign bus.rsp_err      = err_q;
  assign bus.r0_rsp_valid = (state_q == S_RESP) && !owner_q;
  assign bus.r1_rsp_valid = (state_q == S_RESP) &&  owner_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one FPU instance between two requesters (r0, r1), e.g. the integer core's FP issue slot and the load/store helper.
- Arbitrates round-robin and latches the winning command.
- Issues it to the FPU as a single-cycle en pulse, holds ctl/operands stable until the FPU ready pulse, then returns the result to the owner through a valid/ready response handshake.
- Sits between the requesters and the FPU ports clk, rstn, ctl, x1, x2, en, y, ready.

Parameters:
- CTL_W, 5, width of the FPU opcode.
- DATA_W, 32, operand/result width.
- MAX_CTL, 20, highest legal opcode (fsqr); any larger value is rejected.
- TIMEOUT, 31, WAIT-cycle limit; used only with FPU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- r0_valid / r1_valid  in  1  command valid.
- r0_ready / r1_ready  out  1  command accepted this cycle.
- r0_ctl / r1_ctl  in  CTL_W  opcode.
- r0_x1, r0_x2 / r1_x1, r1_x2  in  DATA_W  operands.
- r0_rsp_valid / r1_rsp_valid  out  1  result valid for that requester.
- r0_rsp_ready / r1_rsp_ready  in  1  requester consumes result.
- rsp_y  out  DATA_W  result, shared bus.
- rsp_err  out  1  illegal opcode (or timeout).
- fpu_en  out  1  FPU start pulse.
- fpu_ctl  out  CTL_W  to FPU ctl.
- fpu_x1, fpu_x2  out  DATA_W  to FPU x1, x2.
- fpu_ready  in  1  FPU ready.
- fpu_y  in  DATA_W  FPU y.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rstn sampled on posedge clk, active-low.
  - All outputs 0; state=IDLE; last_grant=1, so r0 wins first.
  - Reset in any state aborts the operation with no response; the FPU shares rstn.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = the valid requester. If both are valid, the one not equal to last_grant wins.
  - rN_ready is combinational: (state==IDLE) && grant==N && rN_valid.
  - On accept, latch ctl/x1/x2 into fpu_ctl/fpu_x1/fpu_x2 and record owner.
  - Legal opcode (ctl<=MAX_CTL): go to ISSUE.
  - Illegal opcode: rsp_y=0, rsp_err=1, go to RESP. The FPU is never touched.
- ISSUE:
  - fpu_en=1 for exactly this cycle, never held longer; a held en restarts the FPU counter.
  - Next state WAIT.
- WAIT:
  - fpu_en=0; fpu_ctl/x1/x2 held unchanged, because the FPU selects its result by ctl at completion.
  - On fpu_ready=1: rsp_y<=fpu_y, rsp_err<=0, go to RESP.
- RESP:
  - rOwner_rsp_valid=1; rsp_y/rsp_err stable; the other rsp_valid stays 0.
  - On rOwner_rsp_ready: go to IDLE, set last_grant<=owner.
  - No new command is accepted until the response is consumed.
- Latency, for an FPU op with N internal stages (fadd/fsub/fmul/finv/fsqr 2, fdiv/sqrt 4, ftoi/itof/floor 1, others 0):
  - Accept cycle A, ISSUE A+1, fpu_ready at A+2+N, rsp_valid first at A+3+N.
  - Illegal opcode: rsp_valid at A+1.
- fpu_ready outside WAIT is ignored.
- Requester valid/operands may change after accept without effect.
- Back-to-back throughput: one op per N+4 cycles with rsp_ready tied high.
- fpu_x1/x2/ctl keep their last values in IDLE; no toggling when idle.

Optional Feature:
- Macro FPU_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no fpu_ready: rsp_y=0, rsp_err=1, go to RESP.
  - A late fpu_ready is ignored.
- Undefined:
  - No counter; WAIT persists until fpu_ready.
  - rsp_err is set only for illegal opcodes.

Test Plan:
- After reset, r0 fadd(ctl=0) x1=0x3F800000, x2=0x40000000 -> r0_ready at A, single fpu_en at A+1, r0_rsp_valid at A+5 with rsp_y=0x40400000, rsp_err=0.
- r1 fabs(ctl=11) x1=0xC0400000 -> r1_rsp_valid at A+3, rsp_y=0x40400000.
- r0 and r1 both valid every cycle with rsp_ready=1 -> grants alternate r0,r1,r0,r1; no requester starved; exactly one rsp_valid high at a time.
- r0 ctl=25 -> r0_rsp_valid at A+1, rsp_err=1, rsp_y=0, fpu_en never asserted.
- r0 fdiv(ctl=4) with r0_rsp_ready=0 for 10 cycles -> rsp_valid/rsp_y held stable, r1_ready stays 0; after rsp_ready=1, IDLE next cycle and r1 is accepted.
- rstn=0 during WAIT of fmul -> next cycle all outputs 0, state IDLE, no rsp_valid. With FPU_ARB_TIMEOUT_EN and fpu_ready forced 0 -> rsp_err=1 after TIMEOUT WAIT cycles.
